// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, direction and bus constants for the burst DMA.
package dma_pkg;
   typedef enum logic [2:0] {
      IDLE, REQUEST, INIT, READ_DATA, WRITE_PRE, WRITE_DATA, END_WRITE, NEXT
   } dma_state_t;
   localparam logic DIR_READ = 1'b1;
   localparam logic DIR_WRITE = 1'b0;
   localparam logic [3:0] BYTE_EN_ALL = 4'hF;
   localparam int DEF_SRAM_AW = 9;
   localparam int DEF_BLK_W = 10;
   localparam int DEF_BURST_W = 8;
endpackage

// File: rtl/dma_beat_counter.sv
// dma_beat_counter: beats for the current burst and the post-burst remaining/address.
module dma_beat_counter
   import dma_pkg::*;
#(
   parameter int BLK_W = DEF_BLK_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic [BLK_W-1:0]   remaining,
   input  logic [BURST_W:0]   burst_len,
   input  logic [31:0]        bus_address,
   output logic [BLK_W-1:0]   beats,
   output logic [BURST_W-1:0] burst_field,
   output logic [BLK_W-1:0]   remaining_next,
   output logic [31:0]        bus_address_next
);
   localparam int CW = (BLK_W > BURST_W + 1) ? BLK_W : BURST_W + 1;
   logic [CW-1:0] rem_x, len_x, min_x;
   assign rem_x = CW'(remaining);
   assign len_x = CW'(burst_len);
   assign min_x = rem_x < len_x ? rem_x : len_x;
   assign beats = BLK_W'(min_x);
   assign burst_field = BURST_W'(min_x - CW'(1));
   assign remaining_next = remaining - beats;
   assign bus_address_next = bus_address + (32'(beats) << 2);
endmodule

// File: rtl/dma_burst_controller.sv
// dma_burst_controller: splits a programmed block into bus bursts between the bus and SSRAM port B.
module dma_burst_controller
   import dma_pkg::*;
#(
   parameter int SRAM_AW = DEF_SRAM_AW,
   parameter int BLK_W = DEF_BLK_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_read,
   input  logic               start_write,
   input  logic [31:0]        bus_start_address,
   input  logic [SRAM_AW-1:0] memory_start_address,
   input  logic [BLK_W-1:0]   block_size,
   input  logic [BURST_W-1:0] burst_size,
   output logic               status_busy,
   output logic               status_error,
   output logic               busRequest,
   input  logic               busGrant,
   output logic               beginTransaction,
   output logic [31:0]        addressData,
   output logic [7:0]         burstSize,
   output logic               readNotWrite,
   output logic [3:0]         byteEnables,
   output logic               dataValid,
   output logic               endTransaction,
   input  logic [31:0]        busIn_address_data,
   input  logic               busIn_data_valid,
   input  logic               busIn_end_transaction,
   input  logic               busIn_busy,
   input  logic               busIn_error,
   output logic [SRAM_AW-1:0] sram_address,
   output logic               sram_we,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata
);
   dma_state_t state;
   logic [31:0] bus_addr, bus_addr_next;
   logic [SRAM_AW-1:0] mem_ptr, wr_addr, fetch_off;
   logic [BLK_W-1:0] remaining, remaining_next, beats, beat_cnt;
   logic [BURST_W:0] burst_len;
   logic [BURST_W-1:0] burst_field;
   logic dir_read, accept, write_phase, last_beat;

   dma_beat_counter #(.BLK_W(BLK_W), .BURST_W(BURST_W)) u_beats (
      .remaining(remaining),
      .burst_len(burst_len),
      .bus_address(bus_addr),
      .beats(beats),
      .burst_field(burst_field),
      .remaining_next(remaining_next),
      .bus_address_next(bus_addr_next)
   );

   assign status_busy = state != IDLE;
   assign accept = state == WRITE_DATA && !busIn_busy;
   assign last_beat = beat_cnt == beats - BLK_W'(1);
   // Write path keeps the next word on sram_rdata; the address steps ahead in the same cycle a beat is taken.
   assign write_phase = dir_read == DIR_WRITE && (state == INIT || state == WRITE_PRE || state == WRITE_DATA);
   assign fetch_off = SRAM_AW'(state != INIT) + SRAM_AW'(accept);
   assign sram_address = write_phase ? mem_ptr + fetch_off : wr_addr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         bus_addr <= '0;
         mem_ptr <= '0;
         wr_addr <= '0;
         remaining <= '0;
         beat_cnt <= '0;
         burst_len <= '0;
         dir_read <= 1'b0;
         status_error <= 1'b0;
         busRequest <= 1'b0;
         beginTransaction <= 1'b0;
         addressData <= '0;
         burstSize <= '0;
         readNotWrite <= 1'b0;
         byteEnables <= '0;
         dataValid <= 1'b0;
         endTransaction <= 1'b0;
         sram_we <= 1'b0;
         sram_wdata <= '0;
      end else if (busIn_error && state != IDLE) begin
         state <= IDLE;
         status_error <= 1'b1;
         busRequest <= 1'b0;
         beginTransaction <= 1'b0;
         addressData <= '0;
         burstSize <= '0;
         readNotWrite <= 1'b0;
         byteEnables <= '0;
         dataValid <= 1'b0;
         endTransaction <= 1'b0;
         sram_we <= 1'b0;
      end else begin
         sram_we <= 1'b0;
         case (state)
            IDLE: if (start_read || start_write) begin
               dir_read <= start_read ? DIR_READ : DIR_WRITE;
               bus_addr <= bus_start_address;
               mem_ptr <= memory_start_address;
               remaining <= block_size;
               burst_len <= (BURST_W+1)'(burst_size) + (BURST_W+1)'(1);
               status_error <= 1'b0;
               busRequest <= block_size != '0;
               state <= block_size == '0 ? NEXT : REQUEST;
            end
            REQUEST: if (busGrant) begin
               state <= INIT;
               beginTransaction <= 1'b1;
               addressData <= bus_addr;
               burstSize <= 8'(burst_field);
               readNotWrite <= dir_read;
               byteEnables <= BYTE_EN_ALL;
               beat_cnt <= '0;
            end
            INIT: begin
               beginTransaction <= 1'b0;
               addressData <= '0;
               state <= dir_read == DIR_READ ? READ_DATA : WRITE_PRE;
            end
            READ_DATA: begin
               if (busIn_data_valid && beat_cnt < beats) begin
                  sram_we <= 1'b1;
                  wr_addr <= mem_ptr;
                  sram_wdata <= busIn_address_data;
                  mem_ptr <= mem_ptr + SRAM_AW'(1);
                  beat_cnt <= beat_cnt + BLK_W'(1);
               end
               if (busIn_end_transaction) begin
                  state <= NEXT;
                  busRequest <= 1'b0;
                  burstSize <= '0;
                  readNotWrite <= 1'b0;
                  byteEnables <= '0;
               end
            end
            WRITE_PRE: begin
               addressData <= sram_rdata;
               dataValid <= 1'b1;
               state <= WRITE_DATA;
            end
            WRITE_DATA: if (!busIn_busy) begin
               mem_ptr <= mem_ptr + SRAM_AW'(1);
               beat_cnt <= beat_cnt + BLK_W'(1);
               addressData <= last_beat ? '0 : sram_rdata;
               dataValid <= !last_beat;
               endTransaction <= last_beat;
               state <= last_beat ? END_WRITE : WRITE_DATA;
            end
            END_WRITE: begin
               endTransaction <= 1'b0;
               busRequest <= 1'b0;
               burstSize <= '0;
               readNotWrite <= 1'b0;
               byteEnables <= '0;
               state <= NEXT;
            end
            NEXT: begin
               remaining <= remaining_next;
               bus_addr <= bus_addr_next;
               busRequest <= remaining_next != '0;
               state <= remaining_next != '0 ? REQUEST : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_burst_controller.sv
// tb_dma_burst_controller: directed table of read transfers plus hand sequences for write, stall, error and start corners.
module tb_dma_burst_controller;
   logic clock = 1'b0, reset = 1'b0;
   logic start_read = 0, start_write = 0;
   logic [31:0] bus_start_address = 0;
   logic [8:0] memory_start_address = 0;
   logic [9:0] block_size = 0;
   logic [7:0] burst_size = 0;
   logic status_busy, status_error, busRequest, beginTransaction, readNotWrite, dataValid, endTransaction;
   logic busGrant = 0, busIn_data_valid = 0, busIn_end_transaction = 0, busIn_busy = 0, busIn_error = 0;
   logic [31:0] addressData, busIn_address_data = 0, sram_wdata, sram_rdata;
   logic [7:0] burstSize;
   logic [3:0] byteEnables;
   logic [8:0] sram_address;
   logic sram_we;
   logic [31:0] mem [512];
   int checks = 0, failures = 0;
   int wn, wend, wunst, wbad;
   logic [31:0] wgot [8];

   typedef struct {
      logic [31:0] bus;
      logic [8:0]  ma;
      logic [9:0]  blk;
      logic [7:0]  bsz;
      int          gdelay;
      int          extra;
      int          exp_bursts;
      logic [31:0] exp_last_addr;
      logic [7:0]  exp_last_sz;
      logic [7:0]  exp_first_sz;
   } vec_t;
   vec_t tbl [5];

   always #5 clock = ~clock;

   dma_burst_controller dut (
      .clock(clock), .reset(reset),
      .start_read(start_read), .start_write(start_write),
      .bus_start_address(bus_start_address), .memory_start_address(memory_start_address),
      .block_size(block_size), .burst_size(burst_size),
      .status_busy(status_busy), .status_error(status_error),
      .busRequest(busRequest), .busGrant(busGrant),
      .beginTransaction(beginTransaction), .addressData(addressData),
      .burstSize(burstSize), .readNotWrite(readNotWrite), .byteEnables(byteEnables),
      .dataValid(dataValid), .endTransaction(endTransaction),
      .busIn_address_data(busIn_address_data), .busIn_data_valid(busIn_data_valid),
      .busIn_end_transaction(busIn_end_transaction), .busIn_busy(busIn_busy), .busIn_error(busIn_error),
      .sram_address(sram_address), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always @(posedge clock) begin
      if (!reset) for (int i = 0; i < 512; i++) mem[i] <= 32'h5A5A0000 | i;
      else if (sram_we) mem[sram_address] <= sram_wdata;
      sram_rdata <= mem[sram_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int v, input int k);
      return 32'hC0DE0000 + 32'(v << 12) + 32'(k);
   endfunction

   task automatic run_read(input int v, output int nb, output logic [7:0] fsz, output logic [7:0] lsz,
                           output logic [31:0] laddr, output int bad);
      int k = 0, t;
      logic [7:0] sz;
      nb = 0; bad = 0; fsz = 0; lsz = 0; laddr = 0;
      @(negedge clock);
      bus_start_address = tbl[v].bus; memory_start_address = tbl[v].ma;
      block_size = tbl[v].blk; burst_size = tbl[v].bsz; start_read = 1;
      @(negedge clock);
      start_read = 0;
      forever begin
         t = 0;
         while (!busRequest && status_busy && t < 50) begin @(negedge clock); t++; end
         if (!status_busy) break;
         if (t >= 50) begin bad++; break; end
         for (int d = 0; d < tbl[v].gdelay; d++) begin
            @(negedge clock);
            if (!busRequest || beginTransaction) bad++;
         end
         busGrant = 1;
         @(negedge clock);
         busGrant = 0;
         if (!beginTransaction || !readNotWrite || byteEnables != 4'hF) bad++;
         sz = burstSize; laddr = addressData;
         if (nb == 0) fsz = sz;
         lsz = sz; nb++;
         @(negedge clock);
         if (beginTransaction) bad++;
         for (int i = 0; i <= int'(sz) + tbl[v].extra; i++) begin
            busIn_data_valid = 1;
            busIn_address_data = i <= int'(sz) ? word(v, k) : 32'hBAD00000;
            if (i <= int'(sz)) k++;
            @(negedge clock);
         end
         busIn_data_valid = 0; busIn_end_transaction = 1;
         @(negedge clock);
         busIn_end_transaction = 0;
         if (busRequest) bad++;
         if (nb > 20) begin bad++; break; end
      end
   endtask

   task automatic run_write(input logic [8:0] ma, input logic [31:0] ba, input int sb, input int sc);
      int t = 0, st = sc;
      logic [31:0] held = 0;
      logic prev_busy = 0;
      wn = 0; wend = -1; wunst = 0; wbad = 0;
      @(negedge clock);
      bus_start_address = ba; memory_start_address = ma; block_size = 4; burst_size = 7; start_write = 1;
      @(negedge clock);
      start_write = 0;
      while (!busRequest && t < 50) begin @(negedge clock); t++; end
      if (t >= 50) begin wbad++; return; end
      busGrant = 1;
      @(negedge clock);
      busGrant = 0;
      if (!beginTransaction || readNotWrite || addressData != ba || burstSize != 8'd3) wbad++;
      t = 0;
      while (status_busy && t < 60) begin
         @(negedge clock);
         t++;
         if (prev_busy && !dataValid) wunst++;
         busIn_busy = 0;
         if (endTransaction) begin
            if (wend < 0) wend = wn; else wbad++;
         end
         if (dataValid) begin
            if (wn == sb && st > 0) begin
               if (st < sc && addressData != held) wunst++;
               held = addressData; busIn_busy = 1; st--;
            end else begin
               if (sc > 0 && wn == sb && addressData != held) wunst++;
               if (wn < 8) wgot[wn] = addressData;
               wn++;
            end
         end
         prev_busy = busIn_busy;
      end
      busIn_busy = 0;
      if (t >= 60) wbad++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int nb, bad, errs, t;
      logic [7:0] fsz, lsz;
      logic [31:0] laddr;
      logic [8:0] idx;
      tbl[0] = '{32'h00001000, 9'd5,   10'd10, 8'd3,   0, 0, 3, 32'h00001020, 8'd1, 8'd3};
      tbl[1] = '{32'h00004000, 9'd100, 10'd1,  8'd0,   0, 1, 1, 32'h00004000, 8'd0, 8'd0};
      tbl[2] = '{32'hFFFFFFF8, 9'd508, 10'd6,  8'd1,   0, 0, 3, 32'h00000008, 8'd1, 8'd1};
      tbl[3] = '{32'h00000100, 9'd0,   10'd5,  8'd255, 0, 0, 1, 32'h00000100, 8'd4, 8'd4};
      tbl[4] = '{32'h00000200, 9'd20,  10'd7,  8'd2,   5, 0, 3, 32'h00000218, 8'd0, 8'd2};

      repeat (3) @(negedge clock);
      reset = 1;
      @(negedge clock);
      chk("reset_busy", status_busy, 0);
      chk("reset_error", status_error, 0);
      chk("reset_req", busRequest, 0);
      chk("reset_begin", beginTransaction, 0);
      chk("reset_ad", addressData, 0);
      chk("reset_be", byteEnables, 0);
      chk("reset_sram", {sram_we, 23'd0, sram_address}, 0);

      run_write(9'd510, 32'h00002000, -1, 0);
      chk("wr_bad", wbad, 0);
      chk("wr_beats", wn, 4);
      chk("wr_end_after", wend, 4);
      chk("wr_w0", wgot[0], 32'h5A5A01FE);
      chk("wr_w1", wgot[1], 32'h5A5A01FF);
      chk("wr_w2", wgot[2], 32'h5A5A0000);
      chk("wr_w3", wgot[3], 32'h5A5A0001);

      run_write(9'd3, 32'h00002400, 1, 3);
      chk("stall_bad", wbad, 0);
      chk("stall_beats", wn, 4);
      chk("stall_end_after", wend, 4);
      chk("stall_stable", wunst, 0);
      chk("stall_w0", wgot[0], 32'h5A5A0003);
      chk("stall_w1", wgot[1], 32'h5A5A0004);
      chk("stall_w2", wgot[2], 32'h5A5A0005);
      chk("stall_w3", wgot[3], 32'h5A5A0006);

      for (int v = 0; v < 5; v++) begin
         run_read(v, nb, fsz, lsz, laddr, bad);
         errs = 0;
         for (int k = 0; k < int'(tbl[v].blk); k++) begin
            idx = tbl[v].ma + 9'(k);
            if (mem[idx] !== word(v, k)) errs++;
         end
         chk($sformatf("rd%0d_bursts", v), nb, tbl[v].exp_bursts);
         chk($sformatf("rd%0d_first_sz", v), fsz, tbl[v].exp_first_sz);
         chk($sformatf("rd%0d_last_sz", v), lsz, tbl[v].exp_last_sz);
         chk($sformatf("rd%0d_last_addr", v), laddr, tbl[v].exp_last_addr);
         chk($sformatf("rd%0d_protocol", v), bad, 0);
         chk($sformatf("rd%0d_sram_errs", v), errs, 0);
         chk($sformatf("rd%0d_busy_end", v), status_busy, 0);
      end
      chk("rd_extra_ignored", mem[101], 32'h5A5A0065);

      @(negedge clock);
      bus_start_address = 32'h3000; memory_start_address = 9'd400; block_size = 8; burst_size = 7; start_read = 1;
      @(negedge clock);
      start_read = 0;
      t = 0;
      while (!busRequest && t < 50) begin @(negedge clock); t++; end
      chk("err_req_seen", busRequest, 1);
      busGrant = 1;
      @(negedge clock);
      busGrant = 0;
      @(negedge clock);
      busIn_data_valid = 1; busIn_address_data = 32'h11112222;
      @(negedge clock);
      busIn_address_data = 32'h33334444; busIn_error = 1;
      @(negedge clock);
      busIn_error = 0; busIn_data_valid = 0;
      chk("err_busy", status_busy, 0);
      chk("err_flag", status_error, 1);
      chk("err_req", busRequest, 0);
      chk("err_be", byteEnables, 0);
      chk("err_beat1", mem[400], 32'h11112222);
      repeat (2) @(negedge clock);
      chk("err_sticky", status_error, 1);

      block_size = 0; start_write = 1;
      @(negedge clock);
      start_write = 0;
      chk("zero_busy_pulse", status_busy, 1);
      chk("zero_err_clear", status_error, 0);
      chk("zero_no_req", busRequest, 0);
      @(negedge clock);
      chk("zero_busy_fall", status_busy, 0);

      bus_start_address = 32'h5000; memory_start_address = 9'd450; block_size = 1; burst_size = 0;
      start_read = 1; start_write = 1;
      @(negedge clock);
      start_read = 0; start_write = 0;
      bus_start_address = 32'h6000; block_size = 3; start_write = 1;
      @(negedge clock);
      start_write = 0;
      t = 0;
      while (!busRequest && t < 50) begin @(negedge clock); t++; end
      busGrant = 1;
      @(negedge clock);
      busGrant = 0;
      chk("both_dir_read", readNotWrite, 1);
      chk("both_addr", addressData, 32'h5000);
      chk("both_sz", burstSize, 0);
      @(negedge clock);
      busIn_data_valid = 1; busIn_address_data = 32'h12345678;
      @(negedge clock);
      busIn_data_valid = 0; busIn_end_transaction = 1;
      @(negedge clock);
      busIn_end_transaction = 0;
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (busRequest) nb++;
      end
      chk("busy_start_ignored", nb, 0);
      chk("both_busy_end", status_busy, 0);
      chk("both_sram", mem[450], 32'h12345678);

      bus_start_address = 32'h7000; memory_start_address = 0; block_size = 4; burst_size = 3; start_read = 1;
      @(negedge clock);
      start_read = 0;
      busGrant = 1;
      @(negedge clock);
      @(negedge clock);
      busGrant = 0;
      #2 reset = 0;
      #1;
      chk("async_busy", status_busy, 0);
      chk("async_req", busRequest, 0);
      chk("async_be", byteEnables, 0);
      chk("async_begin", beginTransaction, 0);
      @(negedge clock);
      reset = 1;
      repeat (3) @(negedge clock);
      chk("async_no_resume", {status_busy, busRequest}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
